// File: rtl/fa_serial_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state codes
// and the bit-counter width helper.
package fa_serial_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must index bits 0..WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    if (width <= 1) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_serial_add_ctrl_fa.sv
// One-bit full-adder cell used as the serial datapath. This is the only
// piece of the adder that may later be swapped for an approximate variant.
module fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/fa_serial_add_ctrl.sv
// Bit-serial adder controller: accepts two operands and a carry-in, walks
// a single full-adder cell over them LSB-first, then holds the result
// until the consumer takes it.
module fa_serial_add_ctrl
  import fa_serial_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at bit 0.
  always_comb begin
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  // Handshake FSM plus operand/sum shift registers and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= c_in;
            sum_sr <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_next;
          carry  <= fa_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = out_valid ? sum_sr : '0;
  assign c_out     = out_valid & carry;

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Self-checking bench for the bit-serial adder controller: a WIDTH=8
// instance for the main behaviour and a WIDTH=1 instance for the
// single-bit corner case, both checked against plain integer addition.
module tb_fa_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, out_valid, out_ready, c_in, c_out, busy;
  logic [7:0] a, b, sum;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1, busy1;
  logic [0:0] a1, b1, sum1;

  int tests;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[7];

  fa_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  fa_serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .c_in      (c_in1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .c_out     (c_out1),
    .busy      (busy1)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present operands, wait for acceptance, return at the negedge after the accept edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int waitc;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    c_in     = cv;
    waitc    = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) checkOutput("accept timeout in_ready", 33'(in_ready), 33'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    c_in     = 1'($urandom);
  endtask

  // Full operation with latency, result, backpressure and release checks.
  task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input int hold);
    logic [8:0] expv;
    int         lat;
    expv      = 9'(av) + 9'(bv) + 9'(cv);
    out_ready = (hold == 0);
    applyStimulus(av, bv, cv);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 33'(lat), 33'd8);
    checkOutput({tag, " sum"}, 33'(sum), 33'(expv[7:0]));
    checkOutput({tag, " c_out"}, 33'(c_out), 33'(expv[8]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, " hold out_valid"}, 33'(out_valid), 33'd1);
      checkOutput({tag, " hold sum"}, 33'(sum), 33'(expv[7:0]));
      checkOutput({tag, " hold c_out"}, 33'(c_out), 33'(expv[8]));
      checkOutput({tag, " hold in_ready"}, 33'(in_ready), 33'd0);
      checkOutput({tag, " hold busy"}, 33'(busy), 33'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, " release out_valid"}, 33'(out_valid), 33'd0);
    checkOutput({tag, " release in_ready"}, 33'(in_ready), 33'd1);
    checkOutput({tag, " release sum gated"}, 33'(sum), 33'd0);
  endtask

  // Main test sequence.
  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] expq[$];
    logic [8:0] e;
    int         last_acc;
    int         pulses;
    logic [2:0] v;
    logic [1:0] e1;

    tests      = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    c_in       = 1'b0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    c_in1      = 1'b0;
    out_ready1 = 1'b0;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, s: 8'h96, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h01, b: 8'h02, c: 1'b0, s: 8'h03, co: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[6] = '{a: 8'hAA, b: 8'h55, c: 1'b1, s: 8'h00, co: 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 33'(in_ready), 33'd1);
    checkOutput("reset out_valid", 33'(out_valid), 33'd0);
    checkOutput("reset busy", 33'(busy), 33'd0);
    checkOutput("reset sum", 33'(sum), 33'd0);
    checkOutput("reset c_out", 33'(c_out), 33'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b1;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c);
      repeat (7) @(negedge clk);
      checkOutput("table not early", 33'(out_valid), 33'd0);
      @(negedge clk);
      checkOutput("table out_valid at 8", 33'(out_valid), 33'd1);
      checkOutput("table sum", 33'(sum), 33'(vecs[i].s));
      checkOutput("table c_out", 33'(c_out), 33'(vecs[i].co));
      @(negedge clk);
      checkOutput("table one-cycle pulse", 33'(out_valid), 33'd0);
    end

    runOp("backpressure", 8'hC3, 8'h7E, 1'b1, 5);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      runOp("random", ra, rb, rc, int'($urandom_range(0, 2)));
    end

    out_ready = 1'b1;
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrun reset out_valid", 33'(out_valid), 33'd0);
    checkOutput("midrun reset sum", 33'(sum), 33'd0);
    checkOutput("midrun reset in_ready", 33'(in_ready), 33'd1);
    checkOutput("midrun reset busy", 33'(busy), 33'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("midrun reset no pulse", 33'(pulses), 33'd0);
    runOp("after reset", 8'h01, 8'h02, 1'b0, 0);

    out_ready = 1'b1;
    last_acc  = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (out_valid) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checkOutput("stream sum", 33'(sum), 33'(e[7:0]));
          checkOutput("stream c_out", 33'(c_out), 33'(e[8]));
        end else begin
          checkOutput("stream unexpected out_valid", 33'(out_valid), 33'd0);
        end
      end
      in_valid = (cyc < 60);
      a        = 8'($urandom);
      b        = 8'($urandom);
      c_in     = 1'($urandom);
      if (in_valid && in_ready) begin
        expq.push_back(9'(a) + 9'(b) + 9'(c_in));
        if (last_acc >= 0) checkOutput("stream accept spacing", 33'(cyc - last_acc), 33'd10);
        last_acc = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("stream all results seen", 33'(expq.size()), 33'd0);

    for (int i = 0; i < 8; i++) begin
      v          = 3'(i);
      e1         = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      a1         = v[0];
      b1         = v[1];
      c_in1      = v[2];
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      checkOutput("w1 in_ready", 33'(in_ready1), 33'd1);
      @(negedge clk);
      in_valid1 = 1'b0;
      checkOutput("w1 run out_valid", 33'(out_valid1), 33'd0);
      checkOutput("w1 run busy", 33'(busy1), 33'd1);
      @(negedge clk);
      checkOutput("w1 out_valid", 33'(out_valid1), 33'd1);
      checkOutput("w1 sum", 33'(sum1), 33'(e1[0]));
      checkOutput("w1 c_out", 33'(c_out1), 33'(e1[1]));
      @(negedge clk);
      checkOutput("w1 release", 33'(out_valid1), 33'd0);
      checkOutput("w1 idle busy", 33'(busy1), 33'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
